// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the freq_div_gen programmable divider.
package freq_div_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // Widest divisor the helper below can handle.
    localparam int unsigned MAX_WIDTH = 64;

    // ceil(n/2) written so that n = all-ones cannot overflow.
    function automatic logic [MAX_WIDTH-1:0] ceil_half(input logic [MAX_WIDTH-1:0] n);
        return (n >> 1) + {{(MAX_WIDTH-1){1'b0}}, n[0]};
    endfunction

endpackage

// File: rtl/freq_div_cfg_shadow.sv
// Shadow configuration for freq_div_gen: capture, pending flag, apply at period
// boundary (or immediately when idle) and the acknowledge pulse.
module freq_div_cfg_shadow
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_RESET  = 1,
    parameter logic        MODE_RESET = MODE_PULSE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_tick,
    input  logic             i_config_div,
    input  logic [WIDTH-1:0] i_din_n,
    input  logic             i_mode_in,
    output logic             o_cfg_pending,
    output logic             o_cfg_ack,
    output logic [WIDTH-1:0] o_div_active,
    output logic             o_mode_active
);

    localparam logic [WIDTH-1:0] DIV_RST_RAW = WIDTH'(DIV_RESET);
    localparam logic [WIDTH-1:0] DIV_RST     = (DIV_RST_RAW == '0) ? WIDTH'(1) : DIV_RST_RAW;

    logic             r_pending;
    logic [WIDTH-1:0] r_sh_div;
    logic             r_sh_mode;
    logic [WIDTH-1:0] r_div;
    logic             r_mode;
    logic             w_apply;

    // A fresh capture always beats an apply in the same cycle.
    assign w_apply = r_pending & ~i_config_div & (~i_enable | i_tick);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
            r_sh_div  <= '0;
            r_sh_mode <= MODE_PULSE;
            r_div     <= DIV_RST;
            r_mode    <= MODE_RESET;
        end else if (i_config_div) begin
            r_pending <= 1'b1;
            r_sh_div  <= (i_din_n == '0) ? WIDTH'(1) : i_din_n;
            r_sh_mode <= i_mode_in;
        end else if (w_apply) begin
            r_pending <= 1'b0;
            r_div     <= r_sh_div;
            r_mode    <= r_sh_mode;
        end
    end

    assign o_cfg_pending = r_pending;
    assign o_cfg_ack     = w_apply;
    assign o_div_active  = r_div;
    assign o_mode_active = r_mode;

endmodule

// File: rtl/freq_div_gen.sv
// Runtime-programmable clock divider producing a TICK enable and a registered CLK_OUT.
// Optional macro FREQ_DIV_TICK_COUNT_EN adds a 16-bit TICK counter output.
module freq_div_gen
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_RESET  = 1,
    parameter logic        MODE_RESET = MODE_PULSE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_config_div,
    input  logic [WIDTH-1:0] i_din_n,
    input  logic             i_mode_in,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_cfg_pending,
    output logic             o_cfg_ack,
    output logic [WIDTH-1:0] o_div_active
`ifdef FREQ_DIV_TICK_COUNT_EN
    ,
    output logic [15:0]      o_tick_count
`endif
);

    logic             w_en;
    logic             w_last;
    logic             w_tick;
    logic             w_ack;
    logic             w_mode;
    logic [WIDTH-1:0] w_div;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_clk_out_next;

    logic             r_armed;
    logic [WIDTH-1:0] r_cnt;
    logic             r_clk_out;

    freq_div_cfg_shadow #(
        .WIDTH      (WIDTH),
        .DIV_RESET  (DIV_RESET),
        .MODE_RESET (MODE_RESET)
    ) u_cfg_shadow (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (w_en),
        .i_tick        (w_tick),
        .i_config_div  (i_config_div),
        .i_din_n       (i_din_n),
        .i_mode_in     (i_mode_in),
        .o_cfg_pending (o_cfg_pending),
        .o_cfg_ack     (w_ack),
        .o_div_active  (w_div),
        .o_mode_active (w_mode)
    );

    // Counting starts only once reset release has been seen at a clock edge.
    assign w_en   = i_enable & r_armed;
    assign w_last = (r_cnt == (w_div - WIDTH'(1)));
    assign w_tick = w_en & w_last;

    always_comb begin
        w_cnt_next     = '0;
        w_clk_out_next = 1'b0;
        if (w_en) begin
            if (!w_last) begin
                w_cnt_next = r_cnt + WIDTH'(1);
            end
            if (w_mode == MODE_SQUARE) begin
                w_clk_out_next = (MAX_WIDTH'(w_cnt_next) < ceil_half(MAX_WIDTH'(w_div)));
            end else begin
                w_clk_out_next = w_tick;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_cnt     <= w_cnt_next;
            r_clk_out <= w_clk_out_next;
        end
    end

`ifdef FREQ_DIV_TICK_COUNT_EN
    logic [15:0] r_tick_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_count <= '0;
        end else if (w_ack) begin
            r_tick_count <= '0;
        end else if (w_tick) begin
            r_tick_count <= r_tick_count + 16'd1;
        end
    end

    assign o_tick_count = r_tick_count;
`endif

    assign o_tick       = w_tick;
    assign o_clk_out    = r_clk_out;
    assign o_cfg_ack    = w_ack;
    assign o_div_active = w_div;

endmodule

// File: tb/tb_freq_div_gen.sv
// Self-checking bench for freq_div_gen: directed literal checks plus randomized
// traffic compared every cycle against a period-position reference model.
module tb_freq_div_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cfg;
    logic [7:0] din;
    logic       md;
    logic       tick;
    logic       clk_out;
    logic       pend;
    logic       ack;
    logic [7:0] div_active;
`ifdef FREQ_DIV_TICK_COUNT_EN
    logic [15:0] tick_count;
`endif

    always #5 clk = ~clk;

    freq_div_gen #(
        .WIDTH      (8),
        .DIV_RESET  (1),
        .MODE_RESET (1'b0)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_config_div  (cfg),
        .i_din_n       (din),
        .i_mode_in     (md),
        .o_tick        (tick),
        .o_clk_out     (clk_out),
        .o_cfg_pending (pend),
        .o_cfg_ack     (ack),
        .o_div_active  (div_active)
`ifdef FREQ_DIV_TICK_COUNT_EN
        ,
        .o_tick_count  (tick_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: period length, mode, position within the current period.
    bit     m_run, m_mode, m_pend, m_sh_mode, m_clk;
    longint m_n, m_sh_n, m_pos;
    int     m_tcnt;

    function automatic bit exp_tick();
        return en && m_run && (m_pos == m_n - 1);
    endfunction

    function automatic bit exp_ack();
        bit e = en && m_run;
        return m_pend && !cfg && (!e || exp_tick());
    endfunction

    task automatic model_reset();
        m_run = 0; m_mode = 0; m_pend = 0; m_sh_mode = 0; m_clk = 0;
        m_n = 1; m_sh_n = 0; m_pos = 0; m_tcnt = 0;
    endtask

    task automatic model_step();
        bit     e = en && m_run;
        bit     t = exp_tick();
        bit     a = exp_ack();
        longint nxt = (e && !t) ? m_pos + 1 : 0;
        if (!e)          m_clk = 0;
        else if (!m_mode) m_clk = t;
        else             m_clk = (nxt < (m_n + 1) / 2);
        if (a)      m_tcnt = 0;
        else if (t) m_tcnt = (m_tcnt + 1) % 65536;
        if (cfg) begin
            m_sh_n = (din == 0) ? 1 : longint'(din);
            m_sh_mode = md;
            m_pend = 1;
        end else if (a) begin
            m_n = m_sh_n;
            m_mode = m_sh_mode;
            m_pend = 0;
        end
        m_pos = nxt;
        m_run = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tick", tick, exp_tick());
            chk("clk_out", clk_out, m_clk);
            chk("cfg_pending", pend, m_pend);
            chk("cfg_ack", ack, exp_ack());
            chk("div_active", div_active, m_n);
`ifdef FREQ_DIV_TICK_COUNT_EN
            chk("tick_count", tick_count, m_tcnt);
`endif
        end
    end

    bit s_tick, s_clk, s_pend, s_ack;
    logic [7:0] s_div;

    task automatic cycle(input bit e, input bit c, input logic [7:0] d, input bit m);
        en = e; cfg = c; din = d; md = m;
        @(negedge clk);
        s_tick = tick; s_clk = clk_out; s_pend = pend; s_ack = ack; s_div = div_active;
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
    endtask

    task automatic load_idle(input logic [7:0] d, input bit m);
        cycle(0, 1, d, m);
        cycle(0, 0, 0, 0);
    endtask

    logic [31:0] v_a, v_b, v_c;
    int          n_t, first_t;

    initial begin
        rst_n = 0; en = 0; cfg = 0; din = 0; md = 0;
        model_reset();
        @(posedge clk); #1;
        chk_en = 1;
        cycle(0, 0, 0, 0);
        chk("rst_div_active", s_div, 1);
        chk("rst_tick", s_tick, 0);
        rst_n = 1;
        cycle(0, 0, 0, 0);

        // N = 1 pulse: TICK every enabled cycle, CLK_OUT from cycle 2.
        v_a = 0; v_b = 0;
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 0, 0, 0);
            v_a[i] = s_tick; v_b[i] = s_clk;
        end
        chk("n1_tick_vec", v_a, 32'b11110);
        chk("n1_clk_vec", v_b, 32'b11100);

        // N = 5 loaded while idle; ACK in the following cycle.
        cycle(0, 1, 5, 0);
        chk("n5_ack_early", s_ack, 0);
        cycle(0, 0, 0, 0);
        chk("n5_ack", s_ack, 1);
        v_a = 0; v_b = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 0, 0, 0);
            v_a[i] = s_tick; v_b[i] = s_clk;
        end
        chk("n5_tick_vec", v_a, (1 << 5) | (1 << 10) | (1 << 15));
        chk("n5_clk_vec", v_b, (1 << 6) | (1 << 11) | (1 << 16));

        // Square mode duty patterns.
        load_idle(5, 1);
        v_a = 0;
        for (int i = 1; i <= 11; i++) begin
            cycle(1, 0, 0, 0); v_a[i] = s_clk;
        end
        chk("sq5_clk_vec", v_a, (1 << 2) | (1 << 3) | (1 << 6) | (1 << 7) | (1 << 8) | (1 << 11));
        load_idle(4, 1);
        v_a = 0;
        for (int i = 1; i <= 9; i++) begin
            cycle(1, 0, 0, 0); v_a[i] = s_clk;
        end
        chk("sq4_clk_vec", v_a, (1 << 2) | (1 << 5) | (1 << 6) | (1 << 9));
        load_idle(1, 1);
        v_a = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle(1, 0, 0, 0); v_a[i] = s_clk;
        end
        chk("sq1_clk_vec", v_a, 32'b1111100);

        // Running N = 6, request N = 3 mid-period.
        load_idle(6, 0);
        v_a = 0; v_b = 0; v_c = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(1, (i == 3), 3, 0);
            v_a[i] = s_tick; v_b[i] = s_pend; v_c[i] = s_ack;
        end
        chk("mid_tick_vec", v_a, (1 << 6) | (1 << 9) | (1 << 12));
        chk("mid_pend_vec", v_b, (1 << 4) | (1 << 5) | (1 << 6));
        chk("mid_ack_vec", v_c, (1 << 6));

        // DIN_n = 0 is stored as 1.
        load_idle(0, 0);
        cycle(0, 0, 0, 0);
        chk("din0_div", s_div, 1);

        // ENABLE dropped mid-period restarts a full period.
        load_idle(4, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        v_a = 0;
        for (int i = 1; i <= 5; i++) begin
            cycle(1, 0, 0, 0); v_a[i] = s_tick;
        end
        chk("reen_tick_vec", v_a, (1 << 4));

        // Largest divisor 2^WIDTH-1.
        load_idle(255, 0);
        n_t = 0; first_t = 0;
        for (int i = 1; i <= 256; i++) begin
            cycle(1, 0, 0, 0);
            if (s_tick) begin
                n_t++;
                if (first_t == 0) first_t = i;
            end
        end
        chk("nmax_div", s_div, 255);
        chk("nmax_tick_count", n_t, 1);
        chk("nmax_tick_pos", first_t, 255);
        chk("nmax_clk_after", s_clk, 1);

        // Async reset mid-period with a pending request.
        load_idle(6, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 2, 1);
        cycle(1, 0, 0, 0);
        chk("pre_rst_pend", s_pend, 1);
        rst_n = 0;
        model_reset();
        #1;
        chk("async_pend", pend, 0);
        chk("async_div", div_active, 1);
        chk("async_tick", tick, 0);
        chk("async_clk", clk_out, 0);
        chk("async_ack", ack, 0);
        cycle(1, 0, 0, 0);
        rst_n = 1;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("post_rst_pend", s_pend, 0);
        chk("post_rst_div", s_div, 1);
        chk("post_rst_tick", s_tick, 1);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                model_reset();
                cycle(1, 0, 0, 0);
                rst_n = 1;
            end
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 7));
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0), d,
                  1'($urandom_range(0, 1)));
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
